// File: rtl/regfile_dec_pkg.sv
// Shared constants and types for the register-file write-enable decoder.
// Defaults describe the 32-entry integer file where X31 reads as zero.
package regfile_dec_pkg;

    localparam int DEF_SEL_W = 5;
    localparam int XZR_INDEX = 31;
    localparam int DEF_CNT_W = 8;

    // Only the zero register is hardwired; writes to it are dropped but counted.
    localparam logic [31:0] DEF_ZERO_MASK = 32'h1 << XZR_INDEX;

    // One in-flight request at the default select width.
    typedef struct packed {
        logic                 valid;
        logic [DEF_SEL_W-1:0] sel;
    } dec_stage_t;

endpackage

// File: rtl/onehot_decoder_n.sv
// Combinational N-to-2^N one-hot decoder with a global enable.
// Output is all zero when en is low.
module onehot_decoder_n #(
    parameter int SEL_W = 5
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic                  en,
    output logic [2**SEL_W-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/regfile_wr_decoder.sv
// Pipelined write-enable decoder for the register file: 1 or 2 register stages,
// hardwired-zero output mask, flush, and a saturating masked-write counter.
module regfile_wr_decoder
    import regfile_dec_pkg::*;
#(
    parameter int                      SEL_W       = DEF_SEL_W,
    parameter int                      PIPE_STAGES = 1,
    parameter logic [(2**SEL_W)-1:0]   ZERO_MASK   = DEF_ZERO_MASK,
    parameter int                      CNT_W       = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_enable,
    input  logic                   flush,
    input  logic                   clr_cnt,
    output logic [(2**SEL_W)-1:0]  out_we,
    output logic                   out_valid,
    output logic [SEL_W-1:0]       out_sel,
    output logic                   masked_hit,
    output logic [CNT_W-1:0]       masked_cnt
);

    localparam int NUM_OUT = 2**SEL_W;

    if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_stages
        $error("regfile_wr_decoder: PIPE_STAGES must be 1 or 2");
    end

    typedef struct packed {
        logic             valid;
        logic [SEL_W-1:0] sel;
    } stage_t;

    // Tap 0 is the incoming request; tap PIPE_STAGES is the output stage.
    logic [PIPE_STAGES:0]              vld_pipe;
    logic [PIPE_STAGES:1]              vld_q;
    logic [PIPE_STAGES:0][SEL_W-1:0]   sel_pipe;
    logic [PIPE_STAGES:1][SEL_W-1:0]   sel_q;

    assign vld_pipe = {vld_q, in_valid & in_enable & ~flush};
    assign sel_pipe = {sel_q, in_sel};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            sel_q <= '0;
        end else begin
            vld_q <= flush ? '0 : vld_pipe[PIPE_STAGES-1:0];
            // sel only moves with a live request so out_sel holds across bubbles
            for (int i = 1; i <= PIPE_STAGES; i++) begin
                if (vld_pipe[i-1] && !flush) sel_q[i] <= sel_pipe[i-1];
            end
        end
    end

    // Request feeding the decoder, one stage ahead of the output register.
    stage_t dec_in;
    logic   dec_masked;
    logic   dec_en;
    logic   masked_nxt;
    logic [NUM_OUT-1:0] dec_onehot;

    assign dec_in     = '{valid: vld_pipe[PIPE_STAGES-1] & ~flush,
                          sel:   sel_pipe[PIPE_STAGES-1]};
    assign dec_masked = ZERO_MASK[dec_in.sel];
    assign dec_en     = dec_in.valid & ~dec_masked;
    assign masked_nxt = dec_in.valid & dec_masked;

    onehot_decoder_n #(
        .SEL_W (SEL_W)
    ) u_dec (
        .sel    (dec_in.sel),
        .en     (dec_en),
        .onehot (dec_onehot)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_we     <= '0;
            masked_hit <= 1'b0;
        end else begin
            out_we     <= dec_onehot;
            masked_hit <= masked_nxt;
        end
    end

    assign out_valid = vld_q[PIPE_STAGES];
    assign out_sel   = sel_q[PIPE_STAGES];

    // Counts on the edge masked_hit rises; clear beats a same-edge increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            masked_cnt <= '0;
        end else if (clr_cnt) begin
            masked_cnt <= '0;
        end else if (masked_nxt && masked_cnt != {CNT_W{1'b1}}) begin
            masked_cnt <= masked_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wr_decoder.sv
// Bench for regfile_wr_decoder: three configurations share one stimulus stream
// and are compared each cycle against a request-history reference model.
module tb_regfile_wr_decoder;

    localparam int NE = 4096;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic in_valid = 1'b0, in_enable = 1'b0, flush = 1'b0, clr_cnt = 1'b0;
    logic [4:0] in_sel = '0;

    logic [31:0] we [3];
    logic        ov [3];
    logic [4:0]  os [3];
    logic        mh [3];
    logic [7:0]  mc0, mc1;
    logic [1:0]  mc2;

    always #5 clk = ~clk;

    regfile_wr_decoder #(.PIPE_STAGES(1), .CNT_W(8)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sel(in_sel),
        .in_enable(in_enable), .flush(flush), .clr_cnt(clr_cnt),
        .out_we(we[0]), .out_valid(ov[0]), .out_sel(os[0]),
        .masked_hit(mh[0]), .masked_cnt(mc0));

    regfile_wr_decoder #(.PIPE_STAGES(2), .CNT_W(8)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sel(in_sel),
        .in_enable(in_enable), .flush(flush), .clr_cnt(clr_cnt),
        .out_we(we[1]), .out_valid(ov[1]), .out_sel(os[1]),
        .masked_hit(mh[1]), .masked_cnt(mc1));

    regfile_wr_decoder #(.PIPE_STAGES(1), .CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sel(in_sel),
        .in_enable(in_enable), .flush(flush), .clr_cnt(clr_cnt),
        .out_we(we[2]), .out_valid(ov[2]), .out_sel(os[2]),
        .masked_hit(mh[2]), .masked_cnt(mc2));

    // Reference model: per-edge history of what was presented.
    bit acc [NE];
    int asel [NE];
    bit fl [NE];
    bit clr [NE];
    int e = 0;
    int base = 0;
    int cnt [3] = '{0, 0, 0};
    int ps [3] = '{1, 2, 1};
    int cmax [3] = '{255, 255, 3};
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d: got %0h expected %0h", tag, d, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_mc(input int d);
        case (d)
            0:       return {24'b0, mc0};
            1:       return {24'b0, mc1};
            default: return {30'b0, mc2};
        endcase
    endfunction

    // Expected outputs after the last edge: the request accepted PIPE_STAGES-1
    // edges earlier survives unless a later edge flushed it or reset cut it off.
    task automatic check_all();
        int le;
        int r;
        bit valid;
        bit masked;
        logic [31:0] exp_we;
        le = e - 1;
        for (int d = 0; d < 3; d++) begin
            r = le - ps[d] + 1;
            valid = 1'b0;
            if (r >= base) valid = acc[r];
            for (int k = r + 1; k <= le; k++) if (k >= 0 && fl[k]) valid = 1'b0;
            masked = valid && (asel[r] == 31);
            exp_we = (valid && !masked) ? (32'h1 << asel[r]) : 32'h0;
            if (clr[le]) cnt[d] = 0;
            else if (masked && cnt[d] < cmax[d]) cnt[d]++;
            chk("out_we", d, we[d], exp_we);
            chk("out_valid", d, {31'b0, ov[d]}, {31'b0, valid});
            chk("masked_hit", d, {31'b0, mh[d]}, {31'b0, masked});
            chk("masked_cnt", d, get_mc(d), cnt[d]);
            if (valid) chk("out_sel", d, {27'b0, os[d]}, asel[r]);
        end
    endtask

    // Called at a negedge: present inputs, take one edge, check at next negedge.
    task automatic step(input bit v, input bit en, input int sel, input bit f, input bit c);
        in_valid = v; in_enable = en; in_sel = sel[4:0]; flush = f; clr_cnt = c;
        acc[e] = v && en && !f;
        asel[e] = sel;
        fl[e] = f;
        clr[e] = c;
        @(posedge clk);
        e++;
        @(negedge clk);
        check_all();
    endtask

    task automatic reset_zero_checks(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk({tag, "_we"}, d, we[d], 32'h0);
            chk({tag, "_valid"}, d, {31'b0, ov[d]}, 32'h0);
            chk({tag, "_hit"}, d, {31'b0, mh[d]}, 32'h0);
            chk({tag, "_cnt"}, d, get_mc(d), 32'h0);
        end
    endtask

    initial begin
        // Power-on reset held across a couple of edges.
        repeat (2) @(negedge clk);
        reset_zero_checks("rst");
        for (int d = 0; d < 3; d++) chk("rst_sel", d, {27'b0, os[d]}, 32'h0);
        reset_n = 1'b1;
        base = e;

        // Single decode of index 5.
        step(1, 1, 5, 0, 0);
        chk("tp_sel5_we", 0, we[0], 32'h0000_0020);
        // Back-to-back, no gaps.
        step(1, 1, 0, 0, 0);
        chk("tp_sel0_we", 0, we[0], 32'h0000_0001);
        step(1, 1, 1, 0, 0);
        step(1, 1, 30, 0, 0);
        chk("tp_sel30_we", 0, we[0], 32'h4000_0000);
        step(0, 1, 3, 0, 0);
        step(0, 1, 3, 0, 0);

        // Masked index three times, then clear racing a fourth masked hit.
        step(1, 1, 31, 0, 0);
        step(1, 1, 31, 0, 0);
        step(1, 1, 31, 0, 0);
        chk("tp_masked3_cnt", 0, get_mc(0), 32'd3);
        step(1, 1, 31, 0, 1);
        chk("tp_clr_wins", 0, get_mc(0), 32'd0);
        step(0, 0, 0, 0, 0);

        // Saturation on the 2-bit counter.
        repeat (5) step(1, 1, 31, 0, 0);
        chk("tp_sat_cnt", 2, get_mc(2), 32'd3);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Valid without enable is a bubble.
        step(1, 0, 4, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Flush on the edge that accepts 9, with 7 still in flight in the 2-stage copy.
        step(1, 1, 7, 0, 0);
        step(1, 1, 9, 1, 0);
        chk("tp_flush_valid", 1, {31'b0, ov[1]}, 32'h0);
        step(0, 0, 0, 0, 0);
        chk("tp_flush_we", 1, we[1], 32'h0);
        step(0, 0, 0, 0, 0);

        // Async reset between edges with a request in flight.
        step(1, 1, 12, 0, 0);
        #2 reset_n = 1'b0;
        #1 reset_zero_checks("midrst");
        for (int d = 0; d < 3; d++) cnt[d] = 0;
        #1 reset_n = 1'b1;
        base = e;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Randomized traffic with a bias toward the masked index.
        for (int i = 0; i < 400; i++) begin
            int s;
            s = ($urandom_range(0, 3) == 0) ? 31 : int'($urandom_range(0, 31));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, s,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wr_decoder.md
Name: regfile_wr_decoder

Overview:
- Parametrised, pipelined N-to-2^N one-hot decoder that drives register-file write enables in the 64-bit datapath.
- Generalises the fixed 3-bit gate-level decoder in four ways: configurable select width, 1 or 2 register stages, a hardwired-zero output mask, and flush and masked-write accounting.
- Sits between writeback-stage control and the register file's per-register write-enable inputs.

Parameters:
- SEL_W, 5, select width; NUM_OUT = 2**SEL_W is derived and not overridable.
- PIPE_STAGES, 1, decode latency in cycles; legal values are 1 and 2; any other value is an elaboration error.
- ZERO_MASK, 32'h8000_0000, NUM_OUT-bit mask; a set bit k means out_we[k] is never asserted (X31/XZR).
- CNT_W, 8, width of the saturating masked-write counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request qualifier.
- in_sel  input  SEL_W  target index, binary; in_sel[0] is the LSB.
- in_enable  input  1  global write enable; request decodes only if in_valid && in_enable.
- flush  input  1  synchronous kill of all in-flight requests.
- clr_cnt  input  1  synchronous clear of masked_cnt.
- out_we  output  NUM_OUT  one-hot write enables, or all zero.
- out_valid  output  1  out_we/out_sel qualifier.
- out_sel  output  SEL_W  index that produced out_we, delayed in step with it.
- masked_hit  output  1  one-cycle pulse, aligned with out_valid, when the request targeted a masked index.
- masked_cnt  output  CNT_W  saturating count of masked requests.

Behaviour:
- Reset (reset_n low, async): out_we=0, out_valid=0, out_sel=0, masked_hit=0, masked_cnt=0, all pipeline stages invalid. Outputs stay 0 while reset is held. First request may be presented on the first rising edge after deassertion.
- Request accepted at edge T when in_valid && in_enable. Results appear at T+PIPE_STAGES.
- No per-request handshake and no stall: one request per cycle, full throughput.
- Decode rule: out_we[k]=1 iff the stage is valid, in_sel==k, and ZERO_MASK[k]==0. Never more than one bit is set.
- out_valid is 1 for every accepted request, including masked ones; out_we is 0 for masked requests.
- masked_hit=1 with out_valid when ZERO_MASK[out_sel]==1. masked_cnt increments in the same cycle that masked_hit rises.
- in_valid with in_enable=0: no stage loaded, bubble propagates, outputs 0 at T+PIPE_STAGES.
- flush at edge T: every stage is invalidated. The request presented at T is also discarded (flush wins). Outputs are 0 from T+1 until new requests emerge.
- masked_cnt saturates at 2^CNT_W-1 and holds; it does not wrap.
- clr_cnt at edge T: masked_cnt=0 at T+1.
- clr_cnt and a masked_hit increment in the same cycle: clear wins, result is 0; the increment is lost.
- flush does not affect masked_cnt, but a flushed request never counts.
- out_sel holds its last value when out_valid=0 (no X propagation). Benches must ignore out_sel when out_valid=0.
- PIPE_STAGES=2: stage 1 registers the request (valid, sel); stage 2 registers the decoded vector. Both stages are cleared by flush.
- Async reset asserted mid-stream clears everything immediately. In-flight requests are lost, with no partial writes.

Decomposition:
- Package regfile_dec_pkg:
  - default SEL_W=5;
  - XZR_INDEX=31;
  - default ZERO_MASK constant;
  - CNT_W default;
  - typedef for the (valid, sel) stage struct.
- Sub-module onehot_decoder_n: purely combinational, parameter SEL_W, ports sel, en, onehot. Instantiated once, ahead of the output register.

Test Plan:
- Reset then in_valid=1, in_enable=1, in_sel=5, PIPE_STAGES=1 -> next cycle out_we=32'h0000_0020, out_valid=1, out_sel=5, masked_hit=0.
- Back-to-back in_sel=0,1,30 on consecutive cycles -> out_we=32'h1, 32'h2, 32'h4000_0000 on three consecutive cycles, no gaps.
- in_sel=31 three times -> out_we=0, out_valid=1, masked_hit=1 each cycle, masked_cnt=3; then clr_cnt and a 4th masked request in the same cycle -> masked_cnt=0.
- CNT_W=2: five masked requests -> masked_cnt counts 1,2,3,3,3 (saturates).
- PIPE_STAGES=2: requests 7 then 9, flush asserted on the edge that accepts 9 -> out_we never shows bits 7 or 9, outputs 0 for the next two cycles.
- reset_n pulled low mid-stream, between edges, with a request in flight -> out_we and out_valid go 0 without waiting for a clock edge; no request emerges after release.
